// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on {rem, quo}; purely combinational.
module div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        // Sign bit clear means the trial subtract fits: keep it and set the quotient bit.
        if (!diff[WIDTH+1]) begin
            rem_out = diff[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring divider, ITER_PER_CYCLE bits per cycle.
// Optional result cache enabled by defining DIV_SEQUENCER_CACHE_EN.
module div_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned N  = XLEN / ITER_PER_CYCLE;
    localparam int unsigned CW = $clog2(N);

    div_state_e      state_q, state_d;
    logic [XLEN:0]   rem_q, rem_d, rem_step;
    logic [XLEN-1:0] quo_q, quo_d, quo_step;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;

    logic            op_signed, a_neg, b_neg, div_zero, overflow, special, cache_hit;
    logic            start, accept_calc;
    logic [XLEN-1:0] a_mag, b_mag, special_data, cache_data, quo_fix, rem_fix;

    assign op_signed    = ~func3[0];
    assign a_neg        = op_signed & operand1[XLEN-1];
    assign b_neg        = op_signed & operand2[XLEN-1];
    assign a_mag        = a_neg ? ~operand1 + 1'b1 : operand1;
    assign b_mag        = b_neg ? ~operand2 + 1'b1 : operand2;
    assign div_zero     = (operand2 == '0);
    assign overflow     = op_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (&operand2);
    assign special      = div_zero | overflow;
    // Both special cases return the dividend in one slot: rem for /0, quotient for overflow.
    assign special_data = func3[1] ? (div_zero ? operand1 : '0) : (div_zero ? '1 : operand1);

    assign start        = (state_q == IDLE) && req_valid && !flush;
    assign accept_calc  = start && !special && !cache_hit;

    assign quo_fix = neg_quo_q ? ~quo_q + 1'b1 : quo_q;
    assign rem_fix = neg_rem_q ? ~rem_q[XLEN-1:0] + 1'b1 : rem_q[XLEN-1:0];

    for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
        logic [XLEN:0]   rem_in, rem_out;
        logic [XLEN-1:0] quo_in, quo_out;
        if (i == 0) begin : g_first
            assign rem_in = rem_q;
            assign quo_in = quo_q;
        end else begin : g_next
            assign rem_in = g_step[i-1].rem_out;
            assign quo_in = g_step[i-1].quo_out;
        end
        div_step #(
            .WIDTH (XLEN)
        ) u_step (
            .rem_in  (rem_in),
            .quo_in  (quo_in),
            .divisor (dvs_q),
            .rem_out (rem_out),
            .quo_out (quo_out)
        );
    end
    assign rem_step = g_step[ITER_PER_CYCLE-1].rem_out;
    assign quo_step = g_step[ITER_PER_CYCLE-1].quo_out;

`ifdef DIV_SEQUENCER_CACHE_EN
    logic            cache_valid_q, cache_signed_q, req_signed_q;
    logic [XLEN-1:0] req_a_q, req_b_q, cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

    assign cache_hit  = cache_valid_q && (cache_a_q == operand1) && (cache_b_q == operand2)
                        && (cache_signed_q == op_signed);
    assign cache_data = func3[1] ? cache_rem_q : cache_quo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            req_signed_q   <= 1'b0;
            req_a_q        <= '0;
            req_b_q        <= '0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
        end else begin
            if (accept_calc) begin
                req_a_q      <= operand1;
                req_b_q      <= operand2;
                req_signed_q <= op_signed;
            end
            if (flush) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == FIX) begin
                cache_valid_q  <= 1'b1;
                cache_a_q      <= req_a_q;
                cache_b_q      <= req_b_q;
                cache_signed_q <= req_signed_q;
                cache_quo_q    <= quo_fix;
                cache_rem_q    <= rem_fix;
            end
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        count_d     = count_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        is_rem_d    = is_rem_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (start && special) begin
                    resp_data_d = special_data;
                    state_d     = DONE;
                end else if (start && cache_hit) begin
                    resp_data_d = cache_data;
                    state_d     = DONE;
                end else if (accept_calc) begin
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    is_rem_d  = func3[1];
                    count_d   = CW'(N - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q - 1'b1;
                if (count_q == '0) state_d = FIX;
            end
            FIX: begin
                resp_data_d = is_rem_q ? rem_fix : quo_fix;
                state_d     = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_rem_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            count_q     <= count_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            is_rem_q    <= is_rem_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;

endmodule
